fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the 8-bit memory address.
- Captures the combinational 16-bit read data into an IF/ID register with a valid flag.
- Handles start, stall, branch/jump redirect, halt, and freezing while the program loader owns the memory.

Parameters:
- PC_W, 8, program counter / memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch
- IMEM_DEPTH, 30, number of implemented instruction memory words (used only by the optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start fetching from IDLE
- inst_load  in  1  loader is writing instruction memory; fetch frozen
- stall  in  1  downstream not ready; hold PC and IF/ID register
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_W  redirect target
- pc_out  out  PC_W  address to instruction memory (current PC)
- imem_rd  in  INSTR_W  combinational read data for pc_out
- if_instr  out  INSTR_W  registered instruction
- if_pc  out  PC_W  address of if_instr
- if_valid  out  1  if_instr is a real instruction
- halted  out  1  fetch is in HALT
- fetch_fault  out  1  address out of range (optional feature; tied 0 otherwise)

Behaviour:
- States: IDLE, FETCH, HALT. The one clock is clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - pc = RESET_PC; if_instr = 0; if_pc = 0
  - if_valid = 0; halted = 0; fetch_fault = 0; state = IDLE
- pc_out is pc at all times; no combinational path from inputs to pc_out.
- Latency: the word at pc_out appears on if_instr one cycle later, with if_valid = 1.
- IDLE:
  - if_valid = 0.
  - Goes to FETCH on the edge where run=1 and inst_load=0.
  - run is level-sampled and ignored outside IDLE.
- FETCH, per-edge priority inst_load > redirect > stall > normal:
  - inst_load=1: go IDLE, if_valid<=0, pc unchanged. Fetch resumes at the same pc on the next run.
  - redirect_valid=1: pc<=redirect_pc, if_valid<=0 (one bubble flush). Applies even while stall=1.
  - stall=1: pc, if_instr, if_pc, if_valid all hold.
  - normal: if_instr<=imem_rd, if_pc<=pc, if_valid<=1, pc<=pc+1 modulo 2^PC_W (8'hFF wraps to 8'h00).
  - imem_rd[15:12]==HALT_OPCODE on a normal edge: the word is captured with if_valid=1, pc does NOT increment, next state HALT.
- HALT:
  - halted=1; if_valid<=0 on the first HALT edge; stall ignored.
  - redirect_valid=1: pc<=redirect_pc, halted<=0, go FETCH.
  - inst_load=1: go IDLE, halted<=0.
  - Otherwise remain.
- All-zero instruction (empty memory) is fetched as an ordinary instruction (NOP); no special treatment.
- Reset mid-operation: immediate return to reset values regardless of state; the in-flight instruction is lost.

Optional Feature:
- FETCH_BOUND_CHECK_EN defined:
  - On a normal FETCH edge with pc >= IMEM_DEPTH: nothing is captured (if_valid<=0), fetch_fault<=1, state HALT.
  - fetch_fault is sticky until reset or inst_load.
  - A redirect to an out-of-range target faults on the following edge.
- Not defined: fetch_fault is tied 0 and the PC range is unchecked; PC wraps at 2^PC_W.

Decomposition:
- Shared header macros:
  - PC_W and INSTR_W defaults
  - HALT_OPCODE
  - state encodings (IDLE=2'd0, FETCH=2'd1, HALT=2'd2)
  - IMEM_DEPTH, shared with instruction memory
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and clear (flush) controls.
- PC logic and FSM stay in fetch_unit.

Test Plan:
- Reset, memory [0]=16'h1234, [1]=16'h5678, run pulse -> pc_out 0,1,2; if_instr 16'h1234 then 16'h5678 with if_pc 0,1 and if_valid=1 from the 2nd edge after run.
- stall high 3 cycles at pc=5 -> pc_out stays 5, if_instr/if_valid unchanged; release -> resumes at 5.
- redirect_valid with redirect_pc=8'h14 while stall=1 -> next pc_out=8'h14, if_valid=0 for one cycle, then the word at 0x14 is captured.
- Word 16'hF000 at address 3 -> captured with if_valid=1, halted=1 next cycle, pc_out stays 3; redirect to 0 -> halted=0, fetch restarts at 0.
- inst_load asserted mid-FETCH at pc=7 -> IDLE, if_valid=0; deassert, run -> fetch resumes at 7.
- With FETCH_BOUND_CHECK_EN, redirect to 8'd30 -> fetch_fault=1, halted=1, no valid capture. Without the macro, pc runs 8'hFF to 8'h00 with no fault.
- Additionally: async rst_n low mid-FETCH -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared widths, halt opcode, memory depth and fetch FSM
//                state encoding for the instruction fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int          PC_W_DEF        = 8;
    localparam int          INSTR_W_DEF     = 16;
    localparam int          OPCODE_W        = 4;
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
    // Number of implemented instruction memory words; shared with the memory.
    localparam int          IMEM_DEPTH_DEF  = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // True when the opcode field of a fetched word is the halt opcode.
    function automatic logic is_halt_opcode(input logic [OPCODE_W-1:0] opcode,
                                            input logic [OPCODE_W-1:0] halt_opcode);
        return (opcode == halt_opcode);
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if_id_reg
//  Description : IF/ID pipeline register. Captures instruction and its
//                address on load, drops the valid flag on clear (flush),
//                and otherwise holds (stall).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit_if_id_reg #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    // Next-value selection: clear beats load; a flush only kills the valid
    // flag, the stale payload is left in place since nothing reads it.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    // Register storage with asynchronous reset to an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule : fetch_unit_if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the program counter, drives
//                the instruction memory address, captures read data into the
//                IF/ID register and sequences IDLE / FETCH / HALT.
//                Optional macro FETCH_BOUND_CHECK_EN enables a fault when a
//                fetch is attempted at or beyond IMEM_DEPTH.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                       PC_W        = PC_W_DEF,
    parameter int                       INSTR_W     = INSTR_W_DEF,
    parameter logic [PC_W-1:0]          RESET_PC    = '0,
    parameter logic [OPCODE_W-1:0]      HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int                       IMEM_DEPTH  = IMEM_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               inst_load,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    output logic               halted,
    output logic               fetch_fault
);

    localparam logic [PC_W:0] C_DEPTH = IMEM_DEPTH[PC_W:0];

    fetch_state_e          state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic                  ifid_load;
    logic                  ifid_clear;
    logic                  pc_out_of_range;
    logic                  halt_word;

    assign halt_word = is_halt_opcode(imem_rd[INSTR_W-1 -: OPCODE_W], HALT_OPCODE);

`ifdef FETCH_BOUND_CHECK_EN
    // Fetch address beyond the implemented memory words.
    assign pc_out_of_range = ({1'b0, pc_q} >= C_DEPTH);
`else
    // Unchecked range: the PC simply wraps at 2^PC_W, so no fault can arise.
    assign pc_out_of_range = 1'b0 & ({1'b0, pc_q} >= C_DEPTH);
`endif

    // Next-state, PC and IF/ID control. Priority inside FETCH is
    // inst_load > redirect > stall > normal fetch. inst_load also wins in
    // HALT so the loader always regains a quiet fetch stage.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ifid_clear = 1'b1;
                if (run && !inst_load) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (inst_load) begin
                    ifid_clear = 1'b1;
                    state_d    = ST_IDLE;
                end else if (redirect_valid) begin
                    ifid_clear = 1'b1;
                    pc_d       = redirect_pc;
                end else if (stall) begin
                    // everything holds
                end else if (pc_out_of_range) begin
                    ifid_clear = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = ST_HALT;
                end else begin
                    ifid_load = 1'b1;
                    if (halt_word) begin
                        // PC parks on the halt word
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end

            ST_HALT: begin
                ifid_clear = 1'b1;
                if (inst_load) begin
                    state_d = ST_IDLE;
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                ifid_clear = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        // A loader session starts from a clean fault status.
        if (inst_load) begin
            fault_d = 1'b0;
        end
    end

    // State, program counter and fault flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_unit_if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .clear    (ifid_clear),
        .instr_in (imem_rd),
        .pc_in    (pc_q),
        .instr    (if_instr),
        .pc       (if_pc),
        .valid    (if_valid)
    );

    assign pc_out      = pc_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_fault = fault_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios
//                followed by randomized control traffic, all compared
//                against a behavioural fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif
    localparam int DEPTH = 30;
    localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, inst_load, stall, redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  pc_out;
    logic [15:0] imem_rd;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid, halted, fetch_fault;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int          m_mode;
    int          m_pc;
    int          m_ipc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_fault;

    always #5 clk = ~clk;

    assign imem_rd = mem[pc_out];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .inst_load      (inst_load),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .imem_rd        (imem_rd),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 0;
        m_ipc   = 0;
        m_instr = 16'h0000;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    // One clock edge of fetch behaviour, from the current inputs.
    task automatic model_step();
        logic [15:0] word;
        word = mem[m_pc];
        if (m_mode == M_IDLE) begin
            if (run && !inst_load) m_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (inst_load) begin
                m_mode  = M_IDLE;
                m_valid = 1'b0;
            end else if (redirect_valid) begin
                m_pc    = int'(redirect_pc);
                m_valid = 1'b0;
            end else if (stall) begin
                m_valid = m_valid;
            end else if (BOUND && m_pc >= DEPTH) begin
                m_valid = 1'b0;
                m_fault = 1'b1;
                m_mode  = M_HALT;
            end else begin
                m_instr = word;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (word[15:12] == 4'hF) m_mode = M_HALT;
                else                     m_pc   = (m_pc + 1) % 256;
            end
        end else begin
            m_valid = 1'b0;
            if (inst_load) begin
                m_mode = M_IDLE;
            end else if (redirect_valid) begin
                m_pc   = int'(redirect_pc);
                m_mode = M_FETCH;
            end
        end
        if (inst_load) m_fault = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_out"},      {8'h00, pc_out},        16'(m_pc));
        check({tag, ".if_instr"},    if_instr,               m_instr);
        check({tag, ".if_pc"},       {8'h00, if_pc},         16'(m_ipc));
        check({tag, ".if_valid"},    {15'h0, if_valid},      {15'h0, m_valid});
        check({tag, ".halted"},      {15'h0, halted},        {15'h0, (m_mode == M_HALT)});
        check({tag, ".fetch_fault"}, {15'h0, fetch_fault},   {15'h0, m_fault});
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        run            = 1'b0;
        inst_load      = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;

        // reset
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // run pulse, first fetches
        run = 1'b1;
        tick("run0");
        run = 1'b0;
        tick("fetch0");
        tick("fetch1");
        check("first_word", if_pc == 8'h01 ? 16'h5678 : 16'h0000, if_instr);

        // stall three cycles at pc 5
        for (int i = 0; i < 20 && m_pc != 5; i++) tick("to5");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall");
        stall = 1'b0;
        tick("unstall");

        // redirect during stall
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h14;
        tick("redir_stall");
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick("redir_bubble");
        tick("redir_cap");

        // halt word at address 3
        mem[3] = 16'hF000;
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        tick("to0");
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("to_halt");
        stall = 1'b1;
        tick("halt_stall0");
        tick("halt_stall1");
        stall = 1'b0;
        redirect_valid = 1'b1;
        tick("halt_redir");
        redirect_valid = 1'b0;
        mem[3] = 16'h3333;
        tick("restart0");

        // inst_load at pc 7 then resume
        for (int i = 0; i < 20 && m_pc != 7; i++) tick("to7");
        inst_load = 1'b1;
        tick("load");
        tick("load_hold");
        inst_load = 1'b0;
        run = 1'b1;
        tick("rerun");
        run = 1'b0;
        tick("resume0");
        tick("resume1");

        // range boundary
        redirect_valid = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
        redirect_pc = 8'd30;
        tick("oob_redir");
        redirect_valid = 1'b0;
        tick("oob_fault");
        tick("oob_sticky");
        inst_load = 1'b1;
        tick("oob_clear");
        inst_load = 1'b0;
        run = 1'b1;
        tick("oob_rerun");
        run = 1'b0;
`else
        redirect_pc = 8'hFE;
        tick("wrap_redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("wrap");
`endif

        // asynchronous reset mid-fetch
        run = 1'b1;
        tick("pre_areset");
        run = 1'b0;
        tick("pre_areset1");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("areset_async");
        @(posedge clk);
        #1;
        check_all("areset_hold");
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int c = 0; c < 400; c++) begin
            run            = ($urandom_range(0, 3) == 0);
            inst_load      = ($urandom_range(0, 15) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40))
                                                         : 8'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_unit
`default_nettype wire
